// File: rtl/rkv_arb_pkg.sv
// Shared types, default sizes and helpers for the rkv bus arbiter.
// Optional feature macro used by the arbiter: RKV_ARB_TIMEOUT_EN.
package rkv_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam int N_REQ_DEF   = 4;
  localparam int AW_DEF      = 8;
  localparam int DW_DEF      = 8;
  localparam int TIMEOUT_DEF = 16;

  // Width needed to index n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rkv_bus_arbiter_if.sv
// Requester-side and shared-bus signals of the rkv bus arbiter.
// master is the arbiter's view, slave is the environment (requesters + bus slave).
interface rkv_bus_arbiter_if
  import rkv_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) ();

  logic [N_REQ-1:0]    m_req;
  logic [N_REQ-1:0]    m_we;
  logic [N_REQ*AW-1:0] m_addr;
  logic [N_REQ*DW-1:0] m_wdata;
  logic [N_REQ-1:0]    m_grt;
  logic [DW-1:0]       m_rdata;
  logic                m_err;

  logic                bus_req;
  logic                bus_we;
  logic [AW-1:0]       bus_addr;
  logic [DW-1:0]       bus_wdata;
  logic                bus_grt;
  logic [DW-1:0]       bus_rdata;

  modport master (
    input  m_req, m_we, m_addr, m_wdata, bus_grt, bus_rdata,
    output m_grt, m_rdata, m_err, bus_req, bus_we, bus_addr, bus_wdata
  );

  modport slave (
    output m_req, m_we, m_addr, m_wdata, bus_grt, bus_rdata,
    input  m_grt, m_rdata, m_err, bus_req, bus_we, bus_addr, bus_wdata
  );

endinterface

// File: rtl/rkv_rr_pick.sv
// Combinational round-robin picker: rotate requests so rr_ptr lands at bit 0,
// take the lowest set bit, then rotate the index back.
module rkv_rr_pick
  import rkv_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  localparam int IW   = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    rr_ptr,
  output logic [IW-1:0]    winner,
  output logic             any_req
);

  logic [N_REQ-1:0] rot;
  logic [IW-1:0]    off;
  logic [IW:0]      sum;

  always_comb begin
    rot = N_REQ'({req, req} >> rr_ptr);
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IW'(i);
    end
    // Un-rotate with an explicit modulo so non-power-of-two N_REQ wraps correctly.
    sum = {1'b0, off} + {1'b0, rr_ptr};
    if (sum >= (IW+1)'(N_REQ)) sum = sum - (IW+1)'(N_REQ);
    winner  = sum[IW-1:0];
    any_req = |req;
  end

endmodule

// File: rtl/rkv_bus_arbiter.sv
// Round-robin arbiter sharing one rkv req/grant bus between N_REQ requesters.
// Define RKV_ARB_TIMEOUT_EN to abort transactions the slave never grants.
module rkv_bus_arbiter
  import rkv_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
`ifdef RKV_ARB_TIMEOUT_EN
  , parameter int TIMEOUT = TIMEOUT_DEF
`endif
) (
  input logic                clk,
  input logic                rst,
  rkv_bus_arbiter_if.master  arb
);

  localparam int IW = idx_width(N_REQ);

  arb_state_e       state, state_d;
  logic [IW-1:0]    rr_ptr, ptr_d;
  logic [IW-1:0]    winner, win_d;
  logic [IW-1:0]    pick;
  logic             any_req;
  logic [IW-1:0]    next_ptr;
  logic [N_REQ-1:0] done_onehot;

  logic             bus_req_q, req_d;
  logic             bus_we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [N_REQ-1:0] grt_q, grt_d;

`ifdef RKV_ARB_TIMEOUT_EN
  localparam int CW = idx_width(TIMEOUT);
  logic [CW-1:0] wait_cnt, cnt_d;
  logic          err_q, err_d;
`endif

  rkv_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req     (arb.m_req),
    .rr_ptr  (rr_ptr),
    .winner  (pick),
    .any_req (any_req)
  );

  assign next_ptr    = (winner == IW'(N_REQ - 1)) ? '0 : winner + IW'(1);
  assign done_onehot = N_REQ'(1) << winner;

  always_comb begin
    state_d = state;
    ptr_d   = rr_ptr;
    win_d   = winner;
    req_d   = bus_req_q;
    we_d    = bus_we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    grt_d   = '0;
`ifdef RKV_ARB_TIMEOUT_EN
    cnt_d   = wait_cnt;
    err_d   = err_q;
`endif
    case (state)
      IDLE: begin
        if (any_req) begin
          win_d   = pick;
          we_d    = arb.m_we[pick];
          addr_d  = arb.m_addr[int'(pick)*AW +: AW];
          wdata_d = arb.m_wdata[int'(pick)*DW +: DW];
          req_d   = 1'b1;
          state_d = BUSY;
`ifdef RKV_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUSY: begin
        // A grant on the same edge as the timeout wins, so it is tested first.
        if (arb.bus_grt) begin
          rdata_d = arb.bus_rdata;
          grt_d   = done_onehot;
          ptr_d   = next_ptr;
          req_d   = 1'b0;
          state_d = RESP;
`ifdef RKV_ARB_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          grt_d   = done_onehot;
          ptr_d   = next_ptr;
          req_d   = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d   = wait_cnt + CW'(1);
`endif
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      winner    <= '0;
      bus_req_q <= 1'b0;
      bus_we_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      grt_q     <= '0;
`ifdef RKV_ARB_TIMEOUT_EN
      wait_cnt  <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      rr_ptr    <= ptr_d;
      winner    <= win_d;
      bus_req_q <= req_d;
      bus_we_q  <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      grt_q     <= grt_d;
`ifdef RKV_ARB_TIMEOUT_EN
      wait_cnt  <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  assign arb.bus_req   = bus_req_q;
  assign arb.bus_we    = bus_we_q;
  assign arb.bus_addr  = addr_q;
  assign arb.bus_wdata = wdata_q;
  assign arb.m_grt     = grt_q;
  assign arb.m_rdata   = rdata_q;
`ifdef RKV_ARB_TIMEOUT_EN
  assign arb.m_err     = err_q;
`else
  assign arb.m_err     = 1'b0;
`endif

endmodule

// File: tb/tb_rkv_bus_arbiter.sv
// Directed plus randomized bench for rkv_bus_arbiter; expected grants come from
// a round-robin reference model over per-requester arrays.
module tb_rkv_bus_arbiter;
  import rkv_arb_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  int   mptr = 0;
  int   last_grant_cyc = 0;
  int   grant_gap = 0;
  int   w;
  int   exp_order[5] = '{0, 1, 2, 3, 0};

  bit         req_on[N];
  logic       we_v[N];
  logic [7:0] addr_v[N];
  logic [7:0] wdata_v[N];

  rkv_bus_arbiter_if #(.N_REQ(N), .AW(8), .DW(8)) arb ();

  rkv_bus_arbiter #(.N_REQ(N), .AW(8), .DW(8)) dut (
    .clk (clk),
    .rst (rst),
    .arb (arb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pack the model's per-requester view onto the interface.
  task automatic apply_stimulus();
    logic [3:0]  r, we;
    logic [31:0] a, d;
    for (int i = 0; i < N; i++) begin
      r[i]         = req_on[i];
      we[i]        = we_v[i];
      a[i*8 +: 8]  = addr_v[i];
      d[i*8 +: 8]  = wdata_v[i];
    end
    arb.m_req   = r;
    arb.m_we    = we;
    arb.m_addr  = a;
    arb.m_wdata = d;
  endtask

  task automatic set_req(input int i, input logic we, input logic [7:0] a, input logic [7:0] d);
    req_on[i]  = 1'b1;
    we_v[i]    = we;
    addr_v[i]  = a;
    wdata_v[i] = d;
    apply_stimulus();
  endtask

  // First pending requester at or after the model pointer, wrapping.
  function automatic int model_pick();
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = (mptr + k) % N;
      if (req_on[idx]) return idx;
    end
    return 0;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mptr = 0;
  endtask

  // One full transaction starting from an IDLE cycle with requests already driven.
  task automatic run_txn(input int lat, input logic [7:0] rd, input bit drop, output int got_w);
    int         exp_w;
    logic [3:0] oh;
    exp_w = model_pick();
    oh = 4'b0001 << exp_w;
    @(posedge clk); #1;
    check_output("bus_req_rise", 32'(arb.bus_req), 1);
    check_output("bus_addr", 32'(arb.bus_addr), 32'(addr_v[exp_w]));
    check_output("bus_we", 32'(arb.bus_we), 32'(we_v[exp_w]));
    check_output("bus_wdata", 32'(arb.bus_wdata), 32'(wdata_v[exp_w]));
    for (int i = 1; i < lat; i++) begin
      @(posedge clk); #1;
      check_output("bus_hold", 32'({arb.bus_req, arb.bus_we, arb.bus_addr, arb.bus_wdata}),
                   32'({1'b1, we_v[exp_w], addr_v[exp_w], wdata_v[exp_w]}));
      check_output("m_grt_busy", 32'(arb.m_grt), 0);
    end
    arb.bus_grt   = 1'b1;
    arb.bus_rdata = rd;
    @(posedge clk); #1;
    arb.bus_grt   = 1'b0;
    arb.bus_rdata = 8'($urandom);
    check_output("m_grt", 32'(arb.m_grt), 32'(oh));
    check_output("m_rdata", 32'(arb.m_rdata), 32'(rd));
    check_output("m_err", 32'(arb.m_err), 0);
    check_output("bus_req_drop", 32'(arb.bus_req), 0);
    got_w = -1;
    for (int i = N - 1; i >= 0; i--) if (arb.m_grt[i]) got_w = i;
    grant_gap = cyc - last_grant_cyc;
    last_grant_cyc = cyc;
    mptr = (exp_w + 1) % N;
    if (drop) begin
      req_on[exp_w] = 1'b0;
      apply_stimulus();
    end
    @(posedge clk); #1;
    check_output("m_grt_one_cycle", 32'(arb.m_grt), 0);
  endtask

  initial begin
    bit any;
    int busy;
    bit got;
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_on[i] = 1'b0; we_v[i] = 1'b0; addr_v[i] = '0; wdata_v[i] = '0;
    end
    apply_stimulus();
    arb.bus_grt   = 1'b0;
    arb.bus_rdata = '0;
    $display("[TB] start, default timeout %0d", TIMEOUT_DEF);

    do_reset();
    check_output("rst_bus_req", 32'(arb.bus_req), 0);
    check_output("rst_bus_we", 32'(arb.bus_we), 0);
    check_output("rst_bus_addr", 32'(arb.bus_addr), 0);
    check_output("rst_bus_wdata", 32'(arb.bus_wdata), 0);
    check_output("rst_m_grt", 32'(arb.m_grt), 0);
    check_output("rst_m_rdata", 32'(arb.m_rdata), 0);
    check_output("rst_m_err", 32'(arb.m_err), 0);

    // Stray slave grant while idle must be ignored.
    arb.bus_grt = 1'b1;
    arb.bus_rdata = 8'hEE;
    @(posedge clk); #1;
    arb.bus_grt = 1'b0;
    check_output("stray_m_grt", 32'(arb.m_grt), 0);
    check_output("stray_bus_req", 32'(arb.bus_req), 0);
    @(posedge clk); #1;
    check_output("stray_m_grt_late", 32'(arb.m_grt), 0);

    set_req(0, 1'b0, 8'h3C, 8'h00);
    run_txn(2, 8'hA5, 1'b1, w);
    check_output("single_read_winner", 32'(w), 0);

    set_req(2, 1'b1, 8'h10, 8'h5A);
    run_txn(3, 8'h77, 1'b1, w);
    check_output("write_winner", 32'(w), 2);

    // Reset in the middle of a transaction, then confirm the pointer restarted at 0.
    set_req(1, 1'b0, 8'h21, 8'h00);
    @(posedge clk); #1;
    check_output("rst_busy_req", 32'(arb.bus_req), 1);
    rst = 1'b1;
    req_on[1] = 1'b0;
    apply_stimulus();
    @(posedge clk); #1;
    rst = 1'b0;
    mptr = 0;
    check_output("midrst_bus_req", 32'(arb.bus_req), 0);
    check_output("midrst_m_grt", 32'(arb.m_grt), 0);
    check_output("midrst_bus_addr", 32'(arb.bus_addr), 0);
    @(posedge clk); #1;
    check_output("midrst_idle", 32'(arb.bus_req), 0);
    set_req(2, 1'b0, 8'h44, 8'h00);
    set_req(3, 1'b1, 8'h55, 8'h66);
    run_txn(1, 8'h12, 1'b1, w);
    check_output("post_rst_winner_a", 32'(w), 2);
    run_txn(2, 8'h34, 1'b1, w);
    check_output("post_rst_winner_b", 32'(w), 3);

    // All four requesting through reset; grants rotate every 3 cycles.
    for (int i = 0; i < N; i++) set_req(i, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
    do_reset();
    for (int t = 0; t < 5; t++) begin
      run_txn(1, 8'($urandom), 1'b0, w);
      check_output("all4_order", 32'(w), 32'(exp_order[t]));
      if (t > 0) check_output("all4_gap", 32'(grant_gap), 3);
    end
    for (int i = 0; i < N; i++) req_on[i] = 1'b0;
    apply_stimulus();

    // Requester 3 is served, then re-requests alongside 1 and 2.
    do_reset();
    set_req(3, 1'b0, 8'h30, 8'h00);
    run_txn(1, 8'h01, 1'b1, w);
    check_output("fair_first", 32'(w), 3);
    set_req(1, 1'b0, 8'h11, 8'h00);
    set_req(2, 1'b1, 8'h22, 8'h2A);
    set_req(3, 1'b1, 8'h33, 8'h3A);
    run_txn(1, 8'h02, 1'b1, w);
    check_output("fair_second", 32'(w), 1);
    run_txn(2, 8'h03, 1'b1, w);
    check_output("fair_third", 32'(w), 2);
    run_txn(1, 8'h04, 1'b1, w);
    check_output("fair_fourth", 32'(w), 3);

    for (int t = 0; t < 24; t++) begin
      any = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!req_on[i] && $urandom_range(0, 1) == 1)
          set_req(i, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        if (req_on[i]) any = 1'b1;
      end
      if (!any) set_req(int'($urandom_range(0, N - 1)), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      run_txn(int'($urandom_range(1, 4)), 8'($urandom), 1'b1, w);
    end

`ifdef RKV_ARB_TIMEOUT_EN
    // Slave never answers: expect an abort after TIMEOUT busy cycles.
    for (int i = 0; i < N; i++) req_on[i] = 1'b0;
    set_req(1, 1'b0, 8'h99, 8'h00);
    @(posedge clk); #1;
    busy = 0;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      if (arb.bus_req) busy++;
      @(posedge clk); #1;
      if (arb.m_grt != 0) got = 1'b1;
    end
    check_output("to_busy_cycles", 32'(busy), 32'(TIMEOUT_DEF));
    check_output("to_m_grt", 32'(arb.m_grt), 32'h2);
    check_output("to_m_err", 32'(arb.m_err), 1);
    check_output("to_m_rdata", 32'(arb.m_rdata), 0);
    check_output("to_bus_req", 32'(arb.bus_req), 0);
    mptr = 2;
    req_on[1] = 1'b0;
    apply_stimulus();
    @(posedge clk); #1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rkv_bus_arbiter.md
# rkv_bus_arbiter

Shares a single rkv-style request/grant bus (req, grt, 8-bit addr, 8-bit data) between N_REQ requesters. Each requester raises a request with an address, write flag and write data. The arbiter picks one winner round-robin, registers that requester's fields onto the shared bus and holds them until the slave returns grant. It then pulses a completion strobe with read data back to the winner. The block sits between the testbench/agent-side masters and a single DUT-side bus port.

## Interface
- N_REQ, 4, number of requesters (2..8)
- AW, 8, address width
- DW, 8, data width
- TIMEOUT, 16, cycles to wait for bus_grt before abort (only with RKV_ARB_TIMEOUT_EN; ≥2)

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- m_req  input  N_REQ  per-requester request, level
- m_we  input  N_REQ  per-requester write flag
- m_addr  input  N_REQ*AW  packed addresses, requester i at [i*AW +: AW]
- m_wdata  input  N_REQ*DW  packed write data, same packing
- m_grt  output  N_REQ  one-hot completion pulse
- m_rdata  output  DW  read data, valid with m_grt
- m_err  output  1  timeout abort flag, valid with m_grt
- bus_req  output  1  shared-bus request
- bus_we  output  1  shared-bus write flag
- bus_addr  output  AW  shared-bus address
- bus_wdata  output  DW  shared-bus write data
- bus_grt  input  1  slave acknowledge, single-cycle pulse
- bus_rdata  input  DW  slave read data, valid with bus_grt

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: if any m_req bit is set, pick the winner round-robin.
  - Search starts at rr_ptr and wraps modulo N_REQ.
  - Register the winner index, m_we, m_addr and m_wdata onto the bus_* outputs.
  - Set bus_req=1 and go to BUSY.
  - With no request, stay in IDLE.
- BUSY: hold bus_req and all bus fields constant.
  - On bus_grt=1: capture bus_rdata, set rr_ptr = (winner+1) mod N_REQ, go to RESP, drop bus_req.
- RESP: m_grt[winner]=1 for exactly one cycle, with m_rdata and m_err. Then return to IDLE.
- Requester rules:
  - Hold m_req and its fields stable until m_grt is seen.
  - Deassert m_req on the edge that ends the RESP cycle.
  - Dropping m_req early is a protocol violation; the transaction still completes, and m_grt still pulses.
- Simultaneous requests: at most one grant per transaction. Non-winners wait; no request starves for longer than N_REQ−1 transactions.
- bus_grt while in IDLE or RESP is ignored.
- Reset values (also applied on rst mid-transaction, with no completion pulse): state=IDLE, rr_ptr=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, m_grt=0, m_rdata=0, m_err=0.

## Timing
- m_req first seen in IDLE at edge T → bus_req=1 after edge T.
- bus_grt sampled at edge T+k (k≥1) → m_grt=1 after edge T+k, for one cycle.
- Earliest next arbitration is the IDLE cycle after RESP. Minimum transaction period is 3 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- RKV_ARB_TIMEOUT_EN defined:
  - A wait counter clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT−1 with no bus_grt, drop bus_req, go to RESP with m_err=1 and m_rdata=0. rr_ptr still advances.
  - bus_grt on that same edge takes priority over the timeout (m_err=0).
- RKV_ARB_TIMEOUT_EN undefined:
  - BUSY waits indefinitely.
  - m_err is tied to 0, and no counter is built.

## Structure
- Package rkv_arb_pkg holds:
  - the state enum (IDLE, BUSY, RESP);
  - default constants N_REQ_DEF=4, AW_DEF=8, DW_DEF=8, TIMEOUT_DEF=16;
  - a function returning the index width ($clog2(N_REQ)).
- Sub-module rkv_rr_pick is combinational.
  - Inputs: req vector and rr_ptr.
  - Outputs: winner index and any_req.
  - Implementation: rotate, priority-encode, un-rotate.
- The top level holds the FSM, registers and the optional timeout counter.

## Test plan
- Single read: m_req=0001, m_we=0, addr0=0x3C; slave gives bus_grt after 2 cycles with rdata=0xA5 → bus_addr=0x3C, bus_we=0; m_grt=0001 with m_rdata=0xA5 for one cycle, m_err=0.
- All four requesters held high from reset, slave grants after 1 cycle each → grant order 0,1,2,3,0, with m_grt pulses exactly 3 cycles apart.
- Fairness: requester 3 releases and re-requests immediately while 1 and 2 are waiting → next grants are 1 then 2 before 3 is served again.
- rst asserted during BUSY (bus_req=1) → next cycle bus_req=0, m_grt=0, rr_ptr=0; a later m_req=0100 is granted normally.
- With RKV_ARB_TIMEOUT_EN and TIMEOUT=16, slave never grants → bus_req drops after 16 BUSY cycles; m_grt pulses with m_err=1, m_rdata=0.
- Write path: requester 2 write, addr=0x10, wdata=0x5A → bus_we=1, bus_wdata=0x5A held stable until bus_grt; a stray bus_grt issued in IDLE earlier produces no m_grt.
